// File: rtl/piso_shift_register.sv
// Parallel-in, serial-out shift register with busy/last framing outputs.
// Optional even-parity trailer bit is enabled by defining PISO_PARITY_EN.
//
// cnt_q phase table (cnt_q | meaning):
//   0            | idle, serial_out held at 0
//   TOTAL..2     | data bits in flight
//   1            | final bit of the word (parity bit when PISO_PARITY_EN)
module piso_shift_register #(
    parameter int WIDTH     = 3,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] parallel_in,
    output logic             serial_out,
    output logic             busy,
    output logic             last
);

`ifdef PISO_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int TOTAL = WIDTH + PAR_BITS;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(TOTAL);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if (WIDTH < 2) begin : g_width_check
        $error("piso_shift_register: WIDTH must be at least 2");
    end

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             data_bit;
    logic             serial_bit;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load) begin
            shreg_d = parallel_in;
            cnt_d   = CNT_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
            if (MSB_FIRST != 0) begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data_bit = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];

`ifdef PISO_PARITY_EN
    // Parity is latched at load so a later abort/reload recomputes it cleanly.
    logic par_q, par_d;

    always_comb begin
        par_d = par_q;
        if (load) begin
            par_d = ^parallel_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign serial_bit = (cnt_q == CNT_ONE) ? par_q : data_bit;
`else
    assign serial_bit = data_bit;
`endif

    assign busy       = (cnt_q != '0);
    assign last       = (cnt_q == CNT_ONE);
    assign serial_out = busy ? serial_bit : 1'b0;

endmodule

// File: tb/tb_piso_shift_register.sv
// Scoreboard bench for piso_shift_register: LSB-first and MSB-first instances
// share stimulus; a queue-of-bits reference model predicts every cycle.
module tb_piso_shift_register;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] parallel_in = '0;
    logic         so_l, busy_l, last_l;
    logic         so_m, busy_m, last_m;

    piso_shift_register #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst), .load(load), .parallel_in(parallel_in),
        .serial_out(so_l), .busy(busy_l), .last(last_l));

    piso_shift_register #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst(rst), .load(load), .parallel_in(parallel_in),
        .serial_out(so_m), .busy(busy_m), .last(last_m));

    always #5 clk = ~clk;

    typedef struct packed {
        logic s_lsb;
        logic s_msb;
        logic busy;
        logic last;
    } exp_t;

    exp_t sb[$];
    bit   ql[$];
    bit   qm[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
        end
    endtask

    // Pending bits of the current word, in transmit order; front is on the wire.
    task automatic model_update(input logic r, input logic l, input logic [W-1:0] d);
        exp_t e;
        if (r) begin
            ql.delete();
            qm.delete();
        end else if (l) begin
            ql.delete();
            qm.delete();
            for (int i = 0; i < W; i++) ql.push_back(d[i]);
            for (int i = W - 1; i >= 0; i--) qm.push_back(d[i]);
`ifdef PISO_PARITY_EN
            ql.push_back(^d);
            qm.push_back(^d);
`endif
        end else if (ql.size() != 0) begin
            void'(ql.pop_front());
            void'(qm.pop_front());
        end
        if (ql.size() == 0) begin
            e = '0;
        end else begin
            e.s_lsb = ql[0];
            e.s_msb = qm[0];
            e.busy  = 1'b1;
            e.last  = (ql.size() == 1);
        end
        sb.push_back(e);
    endtask

    task automatic step(input logic r, input logic l, input logic [W-1:0] d);
        @(negedge clk);
        rst         = r;
        load        = l;
        parallel_in = d;
        @(posedge clk);
        model_update(r, l, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("serial_out_lsb", so_l, e.s_lsb);
            check("serial_out_msb", so_m, e.s_msb);
            check("busy_lsb", busy_l, e.busy);
            check("busy_msb", busy_m, e.busy);
            check("last_lsb", last_l, e.last);
            check("last_msb", last_m, e.last);
        end
    end

    initial begin
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 3'b111);
        idle(4);

        step(1'b0, 1'b1, 3'b001);
        idle(30);
        step(1'b0, 1'b1, 3'b100);
        idle(30);
        step(1'b0, 1'b1, 3'b101);
        idle(30);

        // abort and reload one cycle in
        step(1'b0, 1'b1, 3'b101);
        step(1'b0, 1'b1, 3'b010);
        idle(6);

        // back-to-back: reload on the last bit
        step(1'b0, 1'b1, 3'b110);
        idle(W - 1 + (ql.size() > W ? 1 : 0));
        step(1'b0, 1'b1, 3'b011);
        idle(6);

        // load held high
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3'b110);
        idle(6);

        // reset mid-word
        step(1'b0, 1'b1, 3'b111);
        step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        idle(5);

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 3) == 0),
                 W'($urandom));
        end
        idle(6);

        for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
